// File: rtl/trigger_pulse_stretcher_if.sv
// Trigger/pulse bundle between a trigger source and the pulse stretcher.
// The master drives trig and observes the stretched pulse and status strobes.
interface trigger_pulse_stretcher_if;
  logic trig;
  logic level;
  logic busy;
  logic done;
  logic dropped;

  modport master (output trig, input level, input busy, input done, input dropped);
  modport slave  (input trig, output level, output busy, output done, output dropped);
endinterface

// File: rtl/trigger_pulse_stretcher.sv
// Stretches single-cycle triggers into fixed-width level pulses with a guaranteed low gap,
// queueing at most one trigger that arrives while busy and flagging any trigger it discards.
module trigger_pulse_stretcher #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  trigger_pulse_stretcher_if.slave  bus
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.trig) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        // A retrigger restarts the hold and beats expiry on the final hold cycle.
        if (bus.trig && RETRIGGER) begin
          cnt_d = HOLD_LOAD;
        end else begin
          if (bus.trig) begin
            if (pending_q) dropped_d = 1'b1;
            else           pending_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          // Only one trigger starts the next pulse; a second one in the same cycle is lost.
          if (pending_q || bus.trig) begin
            state_d   = HOLD;
            cnt_d     = HOLD_LOAD;
            pending_d = 1'b0;
            dropped_d = pending_q && bus.trig;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (bus.trig) begin
            if (pending_q) dropped_d = 1'b1;
            else           pending_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  assign bus.level   = (state_q == HOLD);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.dropped = dropped_q;

endmodule
